// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
package mult_share_arbiter_pkg;

    localparam int N_DEFAULT    = 32;
    localparam int NREQ_DEFAULT = 4;

    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Pointer parked on the last requester so requester 0 wins first after reset.
    function automatic int rr_reset_ptr(input int nreq);
        return nreq - 1;
    endfunction

    typedef struct packed {
        logic [$clog2(NREQ_DEFAULT)-1:0] id;
        logic [2*N_DEFAULT-1:0]          product;
    } resp_entry_t;

endpackage

// File: rtl/mult_share_resp_fifo.sv
// Synchronous response FIFO with registered valid flag and occupancy count.
module mult_share_resp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          valid,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          valid_q;
    logic          do_pop;

    assign do_pop = pop & valid_q;

    always_comb begin
        count_d = count_q;
        case ({push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_d;
            // Valid comes straight from a flop so the consumer never sees a decode glitch.
            valid_q <= (count_d != '0);
        end
    end

    assign pop_data = mem[rd_ptr];
    assign valid    = valid_q;
    assign count    = count_q;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier; results tagged and queued
// in a credit-protected response FIFO.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int N          = 32,
    parameter int NREQ       = 4,
    parameter int MUL_LAT    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int IDW        = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    input  logic [2*N-1:0]    mul_product,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [2*N-1:0]    resp_product
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = $clog2(FIFO_DEPTH + MUL_LAT + 1) + 1;
    localparam int EW  = IDW + 2*N;

    logic [IDW-1:0]     rr_ptr;
    logic               run_q;
    logic [MUL_LAT-1:0] tag_v;
    logic [IDW-1:0]     tag_id [MUL_LAT];
    logic [FCW-1:0]     fifo_count;
    logic [CW-1:0]      inflight;
    logic               issue_ok;
    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    logic               grant;
    logic [IDW-1:0]     sel;
    logic [EW-1:0]      fifo_wdata;
    logic [EW-1:0]      fifo_rdata;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            inflight = inflight + CW'(tag_v[i]);
        end
    end

    // Credits are judged purely on registered state; a pop this cycle frees a slot next cycle.
    assign issue_ok = run_q && ((CW'(fifo_count) + inflight) < CW'(FIFO_DEPTH));

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant     = grant_found & issue_ok;
    assign req_ready = grant ? (NREQ'(1) << grant_idx) : '0;
    assign sel       = grant ? grant_idx : '0;
    assign mul_a     = req_a[int'(sel)*N +: N];
    assign mul_b     = req_b[int'(sel)*N +: N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= IDW'(rr_reset_ptr(NREQ));
            run_q  <= 1'b0;
            tag_v  <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            run_q     <= 1'b1;
            tag_v[0]  <= grant;
            tag_id[0] <= grant_idx;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            if (grant) begin
                rr_ptr <= grant_idx;
            end
        end
    end

    // The last tag stage lines up with the product the multiplier is presenting now.
    assign fifo_wdata = {tag_id[MUL_LAT-1], mul_product};

    mult_share_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_v[MUL_LAT-1]),
        .push_data (fifo_wdata),
        .pop       (resp_ready),
        .pop_data  (fifo_rdata),
        .valid     (resp_valid),
        .count     (fifo_count)
    );

    assign resp_id      = fifo_rdata[EW-1 -: IDW];
    assign resp_product = fifo_rdata[2*N-1:0];

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: grant table, scoreboard on responses, corner sequences.
module tb_mult_share_arbiter;
    import mult_share_arbiter_pkg::*;

    localparam int N          = 32;
    localparam int NREQ       = 4;
    localparam int MUL_LAT    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int IDW        = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [N-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic [2*N-1:0]    mul_product;
    logic [2*N-1:0]    mul_p1;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [2*N-1:0]    resp_product;

    mult_share_arbiter #(
        .N          (N),
        .NREQ       (NREQ),
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .IDW        (IDW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_product  (mul_product),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product)
    );

    always #5 clk = ~clk;

    // Two-stage registered multiplier, no reset, no stall.
    always_ff @(posedge clk) begin
        mul_p1      <= 64'(mul_a) * 64'(mul_b);
        mul_product <= mul_p1;
    end

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] exp_ready;
    } vec_t;

    vec_t        vecs [15];
    resp_entry_t sb [$];
    int          errors      = 0;
    int          checks      = 0;
    int          outstanding = 0;
    int          n_issue     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        resp_entry_t e;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.id      = IDW'(i);
                e.product = 64'(req_a[i*N +: N]) * 64'(req_b[i*N +: N]);
                sb.push_back(e);
                outstanding++;
                n_issue++;
                check("mul_a_mux", 64'(mul_a), 64'(req_a[i*N +: N]));
                check("mul_b_mux", 64'(mul_b), 64'(req_b[i*N +: N]));
            end
        end
        check("ready_onehot", 64'($countones(req_ready) <= 1), 64'(1));
        if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("stale_resp_queue_size", 64'(sb.size()), 64'(1));
            end else begin
                e = sb.pop_front();
                check("resp_id", 64'(resp_id), 64'(e.id));
                check("resp_product", resp_product, e.product);
                outstanding--;
            end
        end
        check("credit_bound", 64'(outstanding <= FIFO_DEPTH), 64'(1));
    endtask

    task automatic mid();
        @(negedge clk);
        monitor();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = $urandom;
            req_b[i*N +: N] = $urandom;
        end
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        req_valid   = '0;
        resp_ready  = 1'b0;
        sb.delete();
        outstanding = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        next();
    endtask

    task automatic drain();
        bit done;
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            mid();
            done = (sb.size() == 0) && !resp_valid;
            next();
            if (done) break;
        end
        check("drain_queue_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int base;

        vecs[0]  = '{4'b1111, 4'b0001};
        vecs[1]  = '{4'b1111, 4'b0010};
        vecs[2]  = '{4'b1111, 4'b0100};
        vecs[3]  = '{4'b1111, 4'b1000};
        vecs[4]  = '{4'b1111, 4'b0001};
        vecs[5]  = '{4'b1010, 4'b0010};
        vecs[6]  = '{4'b1010, 4'b1000};
        vecs[7]  = '{4'b1010, 4'b0010};
        vecs[8]  = '{4'b0010, 4'b0010};
        vecs[9]  = '{4'b0000, 4'b0000};
        vecs[10] = '{4'b1000, 4'b1000};
        vecs[11] = '{4'b0010, 4'b0010};
        vecs[12] = '{4'b0000, 4'b0000};
        vecs[13] = '{4'b1111, 4'b0100};
        vecs[14] = '{4'b0101, 4'b0001};

        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        #3;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_id", 64'(resp_id), 64'(0));
        check("rst_resp_product", resp_product, 64'(0));
        check("rst_mul_a", 64'(mul_a), 64'(0));
        check("rst_mul_b", 64'(mul_b), 64'(0));
        apply_reset();

        // Single operation latency.
        req_valid       = 4'b0001;
        req_a[N-1:0]    = 32'hFFFF_FFFF;
        req_b[N-1:0]    = 32'h0000_0002;
        resp_ready      = 1'b0;
        mid();
        check("single_ready_T", 64'(req_ready), 64'(1));
        next();
        req_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            mid();
            check("single_ready_after", 64'(req_ready), 64'(0));
            check("single_resp_valid", 64'(resp_valid), 64'(c == 3));
            if (c == 3) begin
                check("single_resp_id", 64'(resp_id), 64'(0));
                check("single_resp_product", resp_product, 64'h0000_0001_FFFF_FFFE);
            end
            next();
        end
        resp_ready = 1'b1;
        mid();
        next();
        resp_ready = 1'b0;

        // Round-robin grant table from a fresh reset.
        apply_reset();
        for (int v = 0; v < 15; v++) begin
            req_valid  = vecs[v].valid;
            resp_ready = 1'b1;
            set_ops();
            mid();
            check("rr_grant", 64'(req_ready), 64'(vecs[v].exp_ready));
            next();
        end
        drain();

        // Backpressure: credits stop issue at FIFO_DEPTH outstanding.
        resp_ready = 1'b0;
        req_valid  = 4'b1111;
        base       = n_issue;
        for (int c = 0; c < 8; c++) begin
            set_ops();
            mid();
            next();
        end
        mid();
        check("bp_grant_count", 64'(n_issue - base), 64'(FIFO_DEPTH));
        check("bp_ready_full", 64'(req_ready), 64'(0));
        check("bp_resp_valid", 64'(resp_valid), 64'(1));
        next();
        resp_ready = 1'b1;
        mid();
        check("bp_no_grant_on_pop_cycle", 64'(req_ready), 64'(0));
        next();
        set_ops();
        mid();
        check("bp_regrant_after_pop", 64'($countones(req_ready)), 64'(1));
        next();
        for (int c = 0; c < 16; c++) begin
            set_ops();
            resp_ready = 1'($urandom_range(0, 1));
            mid();
            next();
        end
        drain();

        // Reset while ops are in flight and queued.
        resp_ready = 1'b0;
        req_valid  = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            set_ops();
            mid();
            next();
        end
        check("pre_reset_resp_valid", 64'(resp_valid), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mid_reset_resp_valid", 64'(resp_valid), 64'(0));
        check("mid_reset_req_ready", 64'(req_ready), 64'(0));
        sb.delete();
        outstanding = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        next();
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        set_ops();
        mid();
        check("post_reset_first_grant", 64'(req_ready), 64'(1));
        next();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
